id_regfile: RTL and testbench
=============================

Name: id_regfile

Overview:
- General-purpose register file for the MIPS core, at the other end of the EX write path.
- Accepts the write-back triple (wdata, waddr, we) that the execute stage produces, and supplies the two source operands that decode hands to the ALU.
- Holds a per-register in-flight write scoreboard so decode can stall on read-after-write hazards.
- Sits in the ID stage; the write port is driven from the write-back stage.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- CNT_W, 2, width of each scoreboard counter; allows at most 3 writes in flight per register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; rst==0 resets.
- regfile_we_i  input  1  write enable from write-back.
- regfile_waddr_i  input  ADDR_W  write address.
- regfile_wdata_i  input  DATA_W  write data.
- regfile_re_1_i  input  1  read enable, port 1.
- regfile_raddr_1_i  input  ADDR_W  read address, port 1.
- regfile_rdata_1_o  output  DATA_W  read data, port 1.
- regfile_busy_1_o  output  1  port 1 source has a write pending.
- regfile_re_2_i  input  1  read enable, port 2.
- regfile_raddr_2_i  input  ADDR_W  read address, port 2.
- regfile_rdata_2_o  output  DATA_W  read data, port 2.
- regfile_busy_2_o  output  1  port 2 source has a write pending.
- regfile_claim_i  input  1  decode issued an instruction with we=1.
- regfile_claim_addr_i  input  ADDR_W  destination of the claiming instruction.
- regfile_sb_err_o  output  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (rst==0, asynchronous):
  - all registers, all counters and sb_err clear to 0;
  - rdata_1/2 and busy_1/2 drive 0 while rst==0.
- Write: at a rising edge with rst==1, we_i==1 and waddr_i!=0, the register at waddr_i takes wdata_i. Writes to register 0 are discarded; register 0 always reads 0.
- Read (combinational, zero latency):
  - rdata_n = 0 if re_n==0 or raddr_n==0; otherwise the stored register value.
  - Both ports may read the same address.
- Scoreboard: one CNT_W-bit counter per register; register 0 is never tracked.
  - Claim (claim_i==1, claim_addr!=0): counter[claim_addr] increments.
  - Retire (we_i==1, waddr!=0): counter[waddr] decrements.
  - Claim and retire to the same address in the same cycle: counter unchanged.
  - Claim at counter==3: counter holds and sb_err sets.
  - Retire at counter==0: counter holds and sb_err sets.
  - sb_err clears only on reset.
- busy_n = re_n && raddr_n!=0 && counter[raddr_n]!=0. Counter value is the registered value unless REGFILE_BYPASS_EN is defined.
- Reset mid-operation: pending writes are lost and counters zero. Upstream pipeline registers are flushed by the same reset, so no stale retire follows.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first):
  - If we_i==1, waddr_i!=0, re_n==1 and raddr_n==waddr_i, then rdata_n = wdata_i in the same cycle.
  - busy_n excludes the retire happening this cycle (uses counter minus 1 when retiring that address).
  - Removes one stall cycle on write-back/decode overlap.
- Undefined: reads return the pre-edge stored value; busy_n uses the registered counter. Decode stalls one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS, CNT_W;
  - ZERO_REG = 5'd0;
  - CNT_MAX = 2'd3.
- One sub-module: regfile_scoreboard. It holds the counter array, claim/retire update, sb_err and busy lookup. The data array and read muxes stay in id_regfile.

Test Plan:
- Reset: hold rst=0, then release; read r1..r31 on both ports -> rdata=0, busy=0, sb_err=0. Write r5=0xDEADBEEF, pulse rst=0 mid-cycle -> rdata_1(r5)=0 immediately.
- Write/read: write r7=0x12345678; next cycle read r7 on port 1 and port 2 -> both 0x12345678. Write r0=0xFFFFFFFF -> reading r0 returns 0, and busy stays 0 after claiming r0.
- Scoreboard: claim r3 three cycles running -> busy_1(r3)=1; three retires to r3 -> busy drops to 0 after the third edge. A fourth claim at count 3 -> sb_err=1, sticky.
- Simultaneous events: counter[r9]=1; claim r9 and retire r9 in the same cycle -> counter stays 1 and busy stays 1. Retire r10 at count 0 -> sb_err=1.
- Bypass: write r4=0xA5A5A5A5 while reading r4 (count 1) in the same cycle:
  - with REGFILE_BYPASS_EN: rdata=0xA5A5A5A5, busy=0;
  - without: rdata = old value, busy=1.
- re gating: re_1=0 with raddr_1=r7 (holding 0x12345678, claimed) -> rdata_1=0, busy_1=0.

Source files
------------

// File: rtl/id_regfile_pkg.sv
// rtl/id_regfile_pkg.sv - shared widths and constants for the ID-stage register file
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;
   localparam int CNT_W    = 2;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam addr_t ZERO_REG = 5'd0;
   localparam cnt_t  CNT_MAX  = 2'd3;

endpackage

// File: rtl/id_regfile_if.sv
// rtl/id_regfile_if.sv - write-back, read, claim and status signals of the register file
interface id_regfile_if;
   import regfile_pkg::*;

   logic  regfile_we_i;
   addr_t regfile_waddr_i;
   data_t regfile_wdata_i;
   logic  regfile_re_1_i;
   addr_t regfile_raddr_1_i;
   data_t regfile_rdata_1_o;
   logic  regfile_busy_1_o;
   logic  regfile_re_2_i;
   addr_t regfile_raddr_2_i;
   data_t regfile_rdata_2_o;
   logic  regfile_busy_2_o;
   logic  regfile_claim_i;
   addr_t regfile_claim_addr_i;
   logic  regfile_sb_err_o;

   modport master (
      output regfile_we_i, regfile_waddr_i, regfile_wdata_i,
      output regfile_re_1_i, regfile_raddr_1_i, regfile_re_2_i, regfile_raddr_2_i,
      output regfile_claim_i, regfile_claim_addr_i,
      input  regfile_rdata_1_o, regfile_busy_1_o, regfile_rdata_2_o, regfile_busy_2_o,
      input  regfile_sb_err_o
   );

   modport slave (
      input  regfile_we_i, regfile_waddr_i, regfile_wdata_i,
      input  regfile_re_1_i, regfile_raddr_1_i, regfile_re_2_i, regfile_raddr_2_i,
      input  regfile_claim_i, regfile_claim_addr_i,
      output regfile_rdata_1_o, regfile_busy_1_o, regfile_rdata_2_o, regfile_busy_2_o,
      output regfile_sb_err_o
   );

endinterface

// File: rtl/id_regfile_scoreboard.sv
// rtl/id_regfile_scoreboard.sv - per-register in-flight write counters; REGFILE_BYPASS_EN discounts same-cycle retires
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  claim_i,
   input  addr_t claim_addr_i,
   input  logic  retire_i,
   input  addr_t retire_addr_i,
   input  logic  re_1_i,
   input  addr_t raddr_1_i,
   input  logic  re_2_i,
   input  addr_t raddr_2_i,
   output logic  busy_1_o,
   output logic  busy_2_o,
   output logic  sb_err_o
);

   cnt_t cnt_q [NUM_REGS];
   cnt_t cnt_d [NUM_REGS];
   logic err_q;
   logic err_d;

   // next counters: claim +1, retire -1, both to one register cancel; saturate and flag on over/underflow
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (claim_i && claim_addr_i == addr_t'(i) &&
             !(retire_i && retire_addr_i == addr_t'(i))) begin
            if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (retire_i && retire_addr_i == addr_t'(i) &&
                      !(claim_i && claim_addr_i == addr_t'(i))) begin
            if (cnt_q[i] == '0) err_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   // counter array and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   function automatic logic lookup_busy(input logic re, input addr_t raddr);
      cnt_t c;
      c = cnt_q[raddr];
`ifdef REGFILE_BYPASS_EN
      if (retire_i && retire_addr_i == raddr && c != '0) c = c - CNT_W'(1);
`endif
      return rst && re && (raddr != ZERO_REG) && (c != '0);
   endfunction

   assign busy_1_o = lookup_busy(re_1_i, raddr_1_i);
   assign busy_2_o = lookup_busy(re_2_i, raddr_2_i);
   assign sb_err_o = err_q;

endmodule

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - two-read one-write MIPS register file with hazard scoreboard; REGFILE_BYPASS_EN selects write-first reads
module id_regfile
   import regfile_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   id_regfile_if.slave  rf
);

   data_t regs_q [NUM_REGS];
   data_t regs_d [NUM_REGS];

   // write-back port; register 0 is hardwired to zero
   always_comb begin
      regs_d = regs_q;
      if (rf.regfile_we_i && rf.regfile_waddr_i != ZERO_REG)
         regs_d[rf.regfile_waddr_i] = rf.regfile_wdata_i;
      regs_d[0] = '0;
   end

   // data array
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   function automatic data_t read_port(input logic re, input addr_t raddr);
      data_t d;
      d = '0;
      if (rst && re && raddr != ZERO_REG) begin
         d = regs_q[raddr];
`ifdef REGFILE_BYPASS_EN
         if (rf.regfile_we_i && rf.regfile_waddr_i == raddr) d = rf.regfile_wdata_i;
`endif
      end
      return d;
   endfunction

   assign rf.regfile_rdata_1_o = read_port(rf.regfile_re_1_i, rf.regfile_raddr_1_i);
   assign rf.regfile_rdata_2_o = read_port(rf.regfile_re_2_i, rf.regfile_raddr_2_i);

   regfile_scoreboard u_sb (
      .clk           (clk),
      .rst           (rst),
      .claim_i       (rf.regfile_claim_i),
      .claim_addr_i  (rf.regfile_claim_addr_i),
      .retire_i      (rf.regfile_we_i),
      .retire_addr_i (rf.regfile_waddr_i),
      .re_1_i        (rf.regfile_re_1_i),
      .raddr_1_i     (rf.regfile_raddr_1_i),
      .re_2_i        (rf.regfile_re_2_i),
      .raddr_2_i     (rf.regfile_raddr_2_i),
      .busy_1_o      (rf.regfile_busy_1_o),
      .busy_2_o      (rf.regfile_busy_2_o),
      .sb_err_o      (rf.regfile_sb_err_o)
   );

endmodule

// File: tb/tb_id_regfile.sv
// tb/tb_id_regfile.sv - directed and random checks of id_regfile against a behavioural model
module tb_id_regfile;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_regfile_if rf();
   id_regfile dut (.clk(clk), .rst(rst), .rf(rf.slave));

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] mregs [32];
   int          mcnt  [32];
   bit          merr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rdata(input bit re, input int a);
      if (!rst || !re || a == 0) return 32'h0;
      if (BYP && rf.regfile_we_i && int'(rf.regfile_waddr_i) == a) return rf.regfile_wdata_i;
      return mregs[a];
   endfunction

   function automatic logic [31:0] exp_busy(input bit re, input int a);
      int c;
      if (!rst || !re || a == 0) return 32'h0;
      c = mcnt[a];
      if (BYP && rf.regfile_we_i && int'(rf.regfile_waddr_i) == a && c > 0) c = c - 1;
      return (c != 0) ? 32'h1 : 32'h0;
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".rdata1"}, rf.regfile_rdata_1_o, exp_rdata(rf.regfile_re_1_i, int'(rf.regfile_raddr_1_i)));
      chk({tag, ".rdata2"}, rf.regfile_rdata_2_o, exp_rdata(rf.regfile_re_2_i, int'(rf.regfile_raddr_2_i)));
      chk({tag, ".busy1"}, {31'h0, rf.regfile_busy_1_o}, exp_busy(rf.regfile_re_1_i, int'(rf.regfile_raddr_1_i)));
      chk({tag, ".busy2"}, {31'h0, rf.regfile_busy_2_o}, exp_busy(rf.regfile_re_2_i, int'(rf.regfile_raddr_2_i)));
      chk({tag, ".sb_err"}, {31'h0, rf.regfile_sb_err_o}, {31'h0, merr});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = 32'h0;
         mcnt[i]  = 0;
      end
      merr = 1'b0;
   endtask

   task automatic model_edge();
      int  wa, ca;
      bit  c, r;
      if (!rst) return;
      wa = int'(rf.regfile_waddr_i);
      ca = int'(rf.regfile_claim_addr_i);
      c  = rf.regfile_claim_i && ca != 0;
      r  = rf.regfile_we_i && wa != 0;
      if (r) mregs[wa] = rf.regfile_wdata_i;
      if (!(c && r && ca == wa)) begin
         if (c) begin
            if (mcnt[ca] == 3) merr = 1'b1;
            else mcnt[ca]++;
         end
         if (r) begin
            if (mcnt[wa] == 0) merr = 1'b1;
            else mcnt[wa]--;
         end
      end
   endtask

   task automatic drv(input bit we, input int wa, input logic [31:0] wd,
                      input bit re1, input int ra1, input bit re2, input int ra2,
                      input bit cl, input int ca);
      rf.regfile_we_i         = we;
      rf.regfile_waddr_i      = addr_t'(wa);
      rf.regfile_wdata_i      = wd;
      rf.regfile_re_1_i       = re1;
      rf.regfile_raddr_1_i    = addr_t'(ra1);
      rf.regfile_re_2_i       = re2;
      rf.regfile_raddr_2_i    = addr_t'(ra2);
      rf.regfile_claim_i      = cl;
      rf.regfile_claim_addr_i = addr_t'(ca);
   endtask

   // called at posedge+1; checks at the falling edge, then advances the model across the next rising edge
   task automatic step(input string tag);
      #4;
      check_all(tag);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("reset");
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      model_reset();
      drv(0, 0, 0, 1, 5, 1, 9, 0, 0);
      @(posedge clk);
      #1;
      step("rst_hold");
      rst = 1'b1;

      for (int r = 1; r < 32; r++) begin
         drv(0, 0, 0, 1, r, 1, 32 - r, 0, 0);
         step("rst_read");
      end

      drv(0, 0, 0, 0, 0, 0, 0, 1, 5);                 step("claim5");
      drv(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);     step("wr5");
      drv(0, 0, 0, 1, 5, 0, 0, 0, 0);
      #2 check_all("r5_before_rst");
      rst = 1'b0;
      #1 model_reset();
      check_all("r5_async_rst");
      @(posedge clk);
      #1 rst = 1'b1;

      drv(0, 0, 0, 0, 0, 0, 0, 1, 7);                 step("claim7");
      drv(1, 7, 32'h12345678, 1, 7, 0, 0, 0, 0);     step("wr7");
      drv(0, 0, 0, 1, 7, 1, 7, 0, 0);                 step("rd7");
      drv(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 0);     step("wr0");
      drv(0, 0, 0, 1, 0, 1, 0, 0, 0);                 step("rd0");

      for (int k = 0; k < 3; k++) begin
         drv(0, 0, 0, 1, 3, 0, 0, 1, 3);             step("claim3");
      end
      drv(0, 0, 0, 1, 3, 1, 3, 0, 0);                 step("busy3");
      for (int k = 0; k < 3; k++) begin
         drv(1, 3, $urandom, 1, 3, 0, 0, 0, 0);      step("retire3");
      end
      drv(0, 0, 0, 1, 3, 1, 3, 0, 0);                 step("idle3");
      for (int k = 0; k < 4; k++) begin
         drv(0, 0, 0, 1, 3, 0, 0, 1, 3);             step("over3");
      end
      drv(0, 0, 0, 1, 3, 0, 0, 0, 0);                 step("sticky1");
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);                 step("sticky2");
      do_reset();

      drv(0, 0, 0, 0, 0, 0, 0, 1, 9);                 step("claim9");
      drv(1, 9, 32'h99, 1, 9, 0, 0, 1, 9);           step("sim9");
      drv(0, 0, 0, 1, 9, 1, 9, 0, 0);                 step("after_sim9");
      drv(1, 10, 32'h10, 0, 0, 0, 0, 0, 0);          step("under10");
      drv(0, 0, 0, 1, 10, 0, 0, 0, 0);                step("err10");
      do_reset();

      drv(0, 0, 0, 0, 0, 0, 0, 1, 4);                 step("claim4a");
      drv(1, 4, 32'h11111111, 0, 0, 0, 0, 0, 0);     step("wr4a");
      drv(0, 0, 0, 0, 0, 0, 0, 1, 4);                 step("claim4b");
      drv(1, 4, 32'hA5A5A5A5, 1, 4, 1, 4, 0, 0);     step("bypass4");
      drv(0, 0, 0, 1, 4, 1, 4, 0, 0);                 step("rd4");

      drv(0, 0, 0, 0, 0, 0, 0, 1, 7);                 step("claim7b");
      drv(0, 0, 0, 0, 7, 1, 7, 0, 0);                 step("re_gate");
      do_reset();

      for (int n = 0; n < 400; n++) begin
         int wa, ra1, ra2, ca;
         wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
         ra1 = int'($urandom_range(0, 7));
         ra2 = int'($urandom_range(0, 7));
         ca  = int'($urandom_range(0, 7));
         drv($urandom_range(0, 1), wa, $urandom, $urandom_range(0, 3) != 0, ra1,
             $urandom_range(0, 3) != 0, ra2, $urandom_range(0, 1), ca);
         step("random");
         if (n == 200) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
